icache: RTL and testbench

- Direct-mapped instruction cache between the fetch/PC stage and the memory controller's instruction port.
- Serves hits in one cycle.
- On a miss, issues one 32-bit fetch to the memory controller, fills the line, and returns the instruction.
- Supports a flush from branch redirect; any in-flight miss is drained safely.

---
 rtl/icache.sv | 117 +++++++++++
 tb/tb_icache.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache: one 32-bit word per line, 1-cycle hits,
// single-word refill from the memory controller, flush-safe miss handling.
module icache #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetchEn,
   input  logic [ADDR_WIDTH-1:0] fetchAddr,
   input  logic                  flush,
   output logic                  instOutEn,
   output logic [31:0]           inst,
   output logic                  icacheFree,
   output logic                  memInstEn,
   output logic [ADDR_WIDTH-1:0] memInstAddr,
   input  logic                  memInstFree,
   input  logic                  memInstOutEn,
   input  logic [31:0]           memInst
);

   localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int unsigned LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_BITS-1:0]   miss_tag;
   logic                  hit_c;
   logic                  hit_out_c;
   logic                  miss_c;
   logic                  fill_c;
   logic                  fill_out_c;
   logic                  unused_addr_lsb;

   assign fetch_idx       = fetchAddr[INDEX_BITS+1:2];
   assign fetch_tag       = fetchAddr[ADDR_WIDTH-1:INDEX_BITS+2];
   assign miss_idx        = memInstAddr[INDEX_BITS+1:2];
   assign miss_tag        = memInstAddr[ADDR_WIDTH-1:INDEX_BITS+2];
   assign hit_c           = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
   assign unused_addr_lsb = ^fetchAddr[1:0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (fetchEn && !flush && !hit_c) state_nxt = S_REQ;
         S_REQ: begin
            if (flush)            state_nxt = S_IDLE;
            else if (memInstFree) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (memInstOutEn) state_nxt = S_IDLE;
            else if (flush)   state_nxt = S_DRAIN;
         end
         S_DRAIN: if (memInstOutEn) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output / strobe decode; a flush coinciding with the returned word suppresses the pulse
   always_comb begin
      icacheFree = (state == S_IDLE);
      hit_out_c  = (state == S_IDLE) && fetchEn && !flush && hit_c;
      miss_c     = (state == S_IDLE) && fetchEn && !flush && !hit_c;
      memInstEn  = (state == S_REQ) && !flush && memInstFree;
      fill_c     = ((state == S_WAIT) || (state == S_DRAIN)) && memInstOutEn;
      fill_out_c = (state == S_WAIT) && memInstOutEn && !flush;
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instOutEn   <= 1'b0;
         inst        <= 32'd0;
         memInstAddr <= '0;
      end else begin
         instOutEn <= hit_out_c || fill_out_c;
         if (hit_out_c)       inst <= data_mem[fetch_idx];
         else if (fill_out_c) inst <= memInst;
         if (miss_c) memInstAddr <= fetchAddr;
      end
   end

   // Valid bits are cleared by reset; tag/data contents are don't-care until valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         valid           <= '0;
      else if (fill_c) valid[miss_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (fill_c) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= memInst;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetch
// traffic against a line-level behavioural model of the cache contents.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetchEn;
   logic [31:0] fetchAddr;
   logic        flush;
   logic        instOutEn;
   logic [31:0] inst;
   logic        icacheFree;
   logic        memInstEn;
   logic [31:0] memInstAddr;
   logic        memInstFree;
   logic        memInstOutEn;
   logic [31:0] memInst;

   icache #(.ADDR_WIDTH(32), .INDEX_BITS(6)) dut (
      .clk(clk), .rst(rst),
      .fetchEn(fetchEn), .fetchAddr(fetchAddr), .flush(flush),
      .instOutEn(instOutEn), .inst(inst), .icacheFree(icacheFree),
      .memInstEn(memInstEn), .memInstAddr(memInstAddr),
      .memInstFree(memInstFree), .memInstOutEn(memInstOutEn), .memInst(memInst)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: what each of the 64 lines currently holds
   bit          m_valid [64];
   logic [23:0] m_tag   [64];
   logic [31:0] m_data  [64];
   logic [31:0] last_inst;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      last_inst = 32'd0;
   endtask

   // One complete fetch transaction. busy: cycles memInstFree stays low in REQ;
   // lat: cycles from memInstEn to the returned word; flush_at: cycle number
   // (1 = cycle after the fetch) at which flush pulses, 0 for none.
   task automatic fetch(input logic [31:0] addr, input int busy, input int lat,
                        input int flush_at, input bit flush_fetch, input logic [31:0] word);
      logic [5:0] i;
      bit         hit;
      bit         flushed;
      int         c;
      i   = addr[7:2];
      hit = m_valid[i] && (m_tag[i] == addr[31:8]);
      check("free_idle", 32'(icacheFree), 32'd1);
      fetchEn = 1'b1; fetchAddr = addr; flush = flush_fetch;
      memInstFree = (busy == 0);
      step();
      fetchEn = 1'b0; flush = 1'b0;
      if (flush_fetch) begin
         check("drop_out", 32'(instOutEn), 32'd0);
         check("drop_free", 32'(icacheFree), 32'd1);
         check("drop_inst", inst, last_inst);
         return;
      end
      if (hit) begin
         check("hit_out", 32'(instOutEn), 32'd1);
         check("hit_inst", inst, m_data[i]);
         last_inst = m_data[i];
         return;
      end
      check("miss_noout", 32'(instOutEn), 32'd0);
      check("miss_addr", memInstAddr, addr);
      // Request phase: stray fetches must be ignored
      for (c = 1; c <= busy + 1; c++) begin
         memInstFree = (c == busy + 1);
         flush       = (c == flush_at);
         fetchEn     = 1'($urandom_range(0, 1));
         fetchAddr   = $urandom;
         #1;
         check("req_free", 32'(icacheFree), 32'd0);
         check("req_memen", 32'(memInstEn), 32'(memInstFree && !flush));
         check("req_addr", memInstAddr, addr);
         if (flush) begin
            step();
            fetchEn = 1'b0; flush = 1'b0;
            check("reqfl_out", 32'(instOutEn), 32'd0);
            check("reqfl_free", 32'(icacheFree), 32'd1);
            check("reqfl_inst", inst, last_inst);
            return;
         end
         step();
         fetchEn = 1'b0; flush = 1'b0;
      end
      // Wait phase: word returns on the lat-th cycle
      flushed = 1'b0;
      for (int w = 1; w <= lat; w++) begin
         flush        = ((c + w - 1) == flush_at);
         flushed      = flushed || flush;
         memInstOutEn = (w == lat);
         memInst      = (w == lat) ? word : $urandom;
         memInstFree  = 1'($urandom_range(0, 1));
         fetchEn      = 1'($urandom_range(0, 1));
         fetchAddr    = $urandom;
         #1;
         check("wait_memen", 32'(memInstEn), 32'd0);
         check("wait_free", 32'(icacheFree), 32'd0);
         check("wait_addr", memInstAddr, addr);
         check("wait_noout", 32'(instOutEn), 32'd0);
         step();
         fetchEn = 1'b0; flush = 1'b0; memInstOutEn = 1'b0;
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = addr[31:8];
      m_data[i]  = word;
      check("fill_out", 32'(instOutEn), 32'(!flushed));
      if (!flushed) last_inst = word;
      check("fill_inst", inst, last_inst);
      check("fill_free", 32'(icacheFree), 32'd1);
      #1;
      check("after_memen", 32'(memInstEn), 32'd0);
   endtask

   // Reset asserted asynchronously while a miss is outstanding in WAIT
   task automatic reset_in_wait(input logic [31:0] addr);
      fetchEn = 1'b1; fetchAddr = addr; flush = 1'b0; memInstFree = 1'b1;
      step();
      fetchEn = 1'b0;
      #1;
      check("rw_memen", 32'(memInstEn), 32'd1);
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      check("rw_out", 32'(instOutEn), 32'd0);
      check("rw_inst", inst, 32'd0);
      check("rw_memen0", 32'(memInstEn), 32'd0);
      check("rw_addr", memInstAddr, 32'd0);
      check("rw_free", 32'(icacheFree), 32'd1);
      step();
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      rst = 1'b1; fetchEn = 1'b0; fetchAddr = 32'd0; flush = 1'b0;
      memInstFree = 1'b1; memInstOutEn = 1'b0; memInst = 32'd0;
      model_clear();
      #3;
      check("rst_out", 32'(instOutEn), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_memen", 32'(memInstEn), 32'd0);
      check("rst_addr", memInstAddr, 32'd0);
      check("rst_free", 32'(icacheFree), 32'd1);
      step();
      step();
      rst = 1'b0;

      // Cold miss, then three back-to-back hits
      fetch(32'h0000_0100, 0, 5, 0, 1'b0, 32'hDEAD_BEEF);
      for (int k = 0; k < 3; k++) fetch(32'h0000_0100, 0, 1, 0, 1'b0, 32'h0);
      // Conflict on the same index evicts the older tag
      fetch(32'h0000_0200, 0, 2, 0, 1'b0, 32'hCAFE_0200);
      fetch(32'h0000_0100, 0, 3, 0, 1'b0, 32'hBEEF_0100);
      // Busy memory controller
      fetch(32'h0000_0404, 4, 2, 0, 1'b0, 32'h0BAD_F00D);
      // Flush in WAIT, the line is still filled
      fetch(32'h0000_0300, 0, 3, 2, 1'b0, 32'h1234_5678);
      fetch(32'h0000_0300, 0, 1, 0, 1'b0, 32'h0);
      // Flush while in REQ, and flush together with fetchEn
      fetch(32'h0000_0508, 2, 2, 1, 1'b0, 32'h5555_AAAA);
      fetch(32'h0000_0608, 0, 1, 0, 1'b1, 32'h6666_0000);
      fetch(32'h0000_0508, 0, 2, 0, 1'b0, 32'h5555_BBBB);
      // Reset during WAIT clears every line
      reset_in_wait(32'h0000_FF40);
      fetch(32'h0000_0100, 0, 2, 0, 1'b0, 32'h7777_0100);
      fetch(32'h0000_0300, 1, 1, 0, 1'b0, 32'h7777_0300);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         int          busy;
         int          lat;
         int          fl;
         a    = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'd0}
                | {24'd0, 3'($urandom_range(0, 7)), 2'b00, 3'd0};
         busy = $urandom_range(0, 3);
         lat  = $urandom_range(1, 4);
         fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, busy + lat + 1) : 0;
         fetch(a, busy, lat, fl, ($urandom_range(0, 9) == 0), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
